dff_rr_share_ctrl: RTL and testbench

Round-robin arbiter and sequencer that shares one DATA_W-bit holding register among NUM_REQ requesters. Each requester offers data with a valid/ready handshake. The controller grants one requester at a time, loads its data into the shared register, and presents it downstream on a valid/ready output port. It sits in front of any single-register resource that several producers must time-share.

---
 rtl/dff_share_pkg.sv | 16 +
 rtl/rr_pick.sv | 37 +++
 rtl/dff_rr_share_ctrl.sv | 81 ++++++++
 tb/tb_dff_rr_share_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dff_share_pkg.sv
// Shared types and defaults for the round-robin
// shared-register controller.
package dff_share_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int DATA_W_DEF  = 8;
  localparam int CNT_W_DEF   = 16;

  typedef logic [$clog2(NUM_REQ_DEF)-1:0] req_idx_t;

  typedef enum logic {
    ST_EMPTY,
    ST_FULL
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set
// request at or after ptr, wrapping modulo NUM_REQ.
module rr_pick
  import dff_share_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  localparam int IDX_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               found
);

  // Scan from ptr upward; the first hit wins.
  always_comb begin
    int j;
    logic [IDX_W-1:0] jj;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    jj    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j  = (int'(ptr) + k) % NUM_REQ;
      jj = IDX_W'(j);
      if (en && !found && req[jj]) begin
        gnt[jj] = 1'b1;
        idx     = jj;
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dff_rr_share_ctrl.sv
// Round-robin sharing of one holding register
// among NUM_REQ valid/ready producers.
module dff_rr_share_ctrl
  import dff_share_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  localparam int IDX_W = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic [IDX_W-1:0]          out_src,
  input  logic                      out_ready,
  output logic [CNT_W-1:0]          xfer_count
);

  state_t           state;
  state_t           state_d;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] gnt_idx;
  logic             found;
  logic             can_load;

  // FULL can reload in the cycle it drains.
  assign can_load  = (state == ST_EMPTY) || out_ready;
  assign out_valid = (state == ST_FULL);

  rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_pick (
    .req  (req_valid),
    .ptr  (rr_ptr),
    .en   (can_load && reset),
    .gnt  (req_ready),
    .idx  (gnt_idx),
    .found(found)
  );

  // Next state: load fills, drain without load empties.
  always_comb begin
    state_d = state;
    unique case (state)
      ST_EMPTY: begin
        if (found) state_d = ST_FULL;
      end
      ST_FULL: begin
        if (out_ready && !found) state_d = ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= ST_EMPTY;
    else        state <= state_d;
  end

  // Shared register, owner, pointer and counter update on a grant.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_data   <= '0;
      out_src    <= '0;
      rr_ptr     <= '0;
      xfer_count <= '0;
    end else if (found) begin
      out_data   <= req_data[gnt_idx*DATA_W +: DATA_W];
      out_src    <= gnt_idx;
      rr_ptr     <= (gnt_idx == IDX_W'(NUM_REQ-1))
                    ? '0 : gnt_idx + 1'b1;
      xfer_count <= xfer_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_dff_rr_share_ctrl.sv
// Self-checking bench for dff_rr_share_ctrl with
// directed scenarios and a randomized model run.
module tb_dff_rr_share_ctrl;

  logic        clk;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic        out_ready;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_src;
  logic [15:0] xfer_count;

  logic [3:0]  req_ready2;
  logic        out_valid2;
  logic [7:0]  out_data2;
  logic [1:0]  out_src2;
  logic [3:0]  xfer_count2;

  int errors = 0;
  int checks = 0;

  bit         m_full;
  logic [7:0] m_data;
  int         m_src;
  int         m_ptr;
  int         m_cnt;

  dff_rr_share_ctrl dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .out_valid(out_valid),
    .out_data(out_data), .out_src(out_src),
    .out_ready(out_ready), .xfer_count(xfer_count)
  );

  dff_rr_share_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready2), .out_valid(out_valid2),
    .out_data(out_data2), .out_src(out_src2),
    .out_ready(out_ready), .xfer_count(xfer_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int exp_pick(input logic [3:0] v,
                                  input bit ld);
    if (!ld) return -1;
    for (int k = 0; k < 4; k++)
      if (v[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready();
    int g;
    g = exp_pick(req_valid, reset && (!m_full || out_ready));
    if (g < 0) return 4'b0000;
    return 4'(1 << g);
  endfunction

  task automatic tick();
    int g;
    g = exp_pick(req_valid, reset && (!m_full || out_ready));
    if (!reset) begin
      m_full = 0; m_data = 0; m_src = 0;
      m_ptr = 0;  m_cnt = 0;
    end else if (g >= 0) begin
      m_data = req_data[g*8 +: 8];
      m_src  = g;
      m_full = 1;
      m_ptr  = (g + 1) % 4;
      m_cnt  = (m_cnt + 1) % 65536;
    end else if (m_full && out_ready) begin
      m_full = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; req_valid = 4'b1111;
    out_ready = 1'b1; req_data = $urandom;
    tick(); tick();
    #1;
    checks++;
    if (req_ready !== 4'b0000 || out_valid !== 1'b0 ||
        out_data !== 8'h00 || out_src !== 2'd0 ||
        xfer_count !== 16'd0 || xfer_count2 !== 4'd0) begin
      errors++;
      $display("FAIL reset: rdy=%b v=%b d=%h s=%0d c=%0d c4=%0d want all 0",
               req_ready, out_valid, out_data, out_src,
               xfer_count, xfer_count2);
    end
  endtask

  task automatic test_reset_mid();
    reset = 1'b1; req_valid = 4'b0100;
    req_data = 32'h00A5_0000;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL mid_grant: got %b want 0100", req_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5) begin
      errors++;
      $display("FAIL mid_load: v=%b d=%h want 1 a5",
               out_valid, out_data);
    end
    reset = 1'b0; req_valid = 4'b1111;
    #1;
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL mid_rst_rdy: got %b want 0000", req_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 ||
        xfer_count !== 16'd0) begin
      errors++;
      $display("FAIL mid_rst: v=%b d=%h c=%0d want 0 00 0",
               out_valid, out_data, xfer_count);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL mid_first: got %b want 0001", req_ready);
    end
    tick();
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 4'b0010; req_data = 32'h0000_3C00;
    out_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL single_rdy: got %b want 0010", req_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h3C ||
        out_src !== 2'd1 || xfer_count !== 16'd1) begin
      errors++;
      $display("FAIL single_out: v=%b d=%h s=%0d c=%0d want 1 3c 1 1",
               out_valid, out_data, out_src, xfer_count);
    end
  endtask

  task automatic test_fairness();
    logic [7:0] want;
    do_reset();
    req_valid = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      req_data = $urandom;
      want = req_data[(i % 4)*8 +: 8];
      #1;
      checks++;
      if (req_ready !== 4'(1 << (i % 4))) begin
        errors++;
        $display("FAIL fair_rdy[%0d]: got %b want %b",
                 i, req_ready, 4'(1 << (i % 4)));
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_src !== 2'(i % 4) ||
          out_data !== want) begin
        errors++;
        $display("FAIL fair_out[%0d]: v=%b s=%0d d=%h want 1 %0d %h",
                 i, out_valid, out_src, out_data, i % 4, want);
      end
    end
    checks++;
    if (xfer_count !== 16'd8) begin
      errors++;
      $display("FAIL fair_cnt: got %0d want 8", xfer_count);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] held;
    held = m_data;
    out_ready = 1'b0; req_valid = 4'b1000;
    for (int i = 0; i < 5; i++) begin
      req_data = $urandom;
      #1;
      checks++;
      if (req_ready !== 4'b0000) begin
        errors++;
        $display("FAIL bp_rdy[%0d]: got %b want 0000", i, req_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== held) begin
        errors++;
        $display("FAIL bp_hold[%0d]: v=%b d=%h want 1 %h",
                 i, out_valid, out_data, held);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b1000) begin
      errors++;
      $display("FAIL bp_release: got %b want 1000", req_ready);
    end
    tick();
    checks++;
    if (out_src !== 2'd3 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_src: s=%0d v=%b want 3 1", out_src, out_valid);
    end
  endtask

  task automatic test_wrap_skip();
    do_reset();
    out_ready = 1'b1; req_valid = 4'b0100;
    req_data = $urandom;
    tick();
    req_valid = 4'b0101;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL wrap_rdy: got %b want 0001", req_ready);
    end
    tick();
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL skip_rdy: got %b want 0100", req_ready);
    end
    tick();
    checks++;
    if (out_src !== 2'd2) begin
      errors++;
      $display("FAIL skip_src: got %0d want 2", out_src);
    end
  endtask

  task automatic test_counter_wrap();
    do_reset();
    out_ready = 1'b1; req_valid = 4'b1111;
    repeat (17) begin
      req_data = $urandom;
      tick();
    end
    checks++;
    if (xfer_count2 !== 4'd1 || xfer_count !== 16'd17) begin
      errors++;
      $display("FAIL cnt_wrap: c4=%0d c16=%0d want 1 17",
               xfer_count2, xfer_count);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      reset     = ($urandom_range(0, 39) != 0);
      req_valid = 4'($urandom);
      req_data  = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      checks++;
      if (req_ready !== exp_ready()) begin
        errors++;
        $display("FAIL rnd_rdy[%0d]: got %b want %b",
                 i, req_ready, exp_ready());
      end
      tick();
      checks++;
      if (out_valid !== m_full ||
          (m_full && (out_data !== m_data || out_src !== 2'(m_src))) ||
          xfer_count !== 16'(m_cnt) || xfer_count2 !== 4'(m_cnt % 16)) begin
        errors++;
        $display("FAIL rnd_out[%0d]: v=%b d=%h s=%0d c=%0d want %b %h %0d %0d",
                 i, out_valid, out_data, out_src, xfer_count,
                 m_full, m_data, m_src, m_cnt);
      end
    end
  endtask

  initial begin
    reset = 1'b0; req_valid = '0;
    req_data = '0; out_ready = 1'b0;
    m_full = 0; m_data = 0; m_src = 0;
    m_ptr = 0;  m_cnt = 0;
    test_reset();
    test_reset_mid();
    test_single();
    test_fairness();
    test_backpressure();
    test_wrap_skip();
    test_counter_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
